// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: bus widths, memory op codes
// and small op-decoding helpers used by the stage and its load extender.
// Op codes above OP_SW are not memory ops; the helpers classify them as NOP.
package mem_pkg;

  localparam int REG_W      = 32;  // RegBus     = 31:0
  localparam int REG_ADDR_W = 5;   // RegAddrBus = 4:0
  localparam int MEM_OP_W   = 4;   // MemOpBus   = 3:0
  localparam int BYTE_W     = 8;   // MemByteBus = 7:0

  localparam logic Enable = 1'b1;
  localparam logic Stop   = 1'b0;

  localparam logic [MEM_OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [MEM_OP_W-1:0] OP_LB  = 4'd1;
  localparam logic [MEM_OP_W-1:0] OP_LH  = 4'd2;
  localparam logic [MEM_OP_W-1:0] OP_LW  = 4'd3;
  localparam logic [MEM_OP_W-1:0] OP_LBU = 4'd4;
  localparam logic [MEM_OP_W-1:0] OP_LHU = 4'd5;
  localparam logic [MEM_OP_W-1:0] OP_SB  = 4'd6;
  localparam logic [MEM_OP_W-1:0] OP_SH  = 4'd7;
  localparam logic [MEM_OP_W-1:0] OP_SW  = 4'd8;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Number of bytes moved by a memory op (0 for non-memory codes).
  function automatic logic [2:0] op_nbytes(input logic [MEM_OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result extender: turns the assembled little-endian load buffer into the
// 32-bit register value, sign-extending LB/LH and zero-extending LBU/LHU/LW.
// Ports: ld_buf (assembled bytes, unused high bytes are 0), op (mem op), word (result).
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [REG_W-1:0]    ld_buf,
  input  logic [MEM_OP_W-1:0] op,
  output logic [REG_W-1:0]    word
);

  always_comb begin
    word = ld_buf;
    case (op)
      OP_LB:   word = {{24{ld_buf[7]}}, ld_buf[7:0]};
      OP_LH:   word = {{16{ld_buf[15]}}, ld_buf[15:0]};
      OP_LBU:  word = {24'd0, ld_buf[7:0]};
      OP_LHU:  word = {16'd0, ld_buf[15:0]};
      default: word = ld_buf;
    endcase
  end

endmodule

// File: rtl/mem.sv
// Memory-access pipeline stage: ALU results pass through, loads/stores run byte-serially.
// Latency: pass-through ops 0 cycles; n-byte access stalls n+1 cycles plus one per wait state.
// Backpressure: stallreq_mem freezes the pipeline while an access is in flight; mc_ready stretches bytes.
// Ports: ex_* from ex_mem, mem_* to mem_wb/forwarding, mc_* byte-wide memory-controller port.
module mem
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_we,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [REG_W-1:0]      ex_wdata,
  input  logic [MEM_OP_W-1:0]   ex_mem_op,
  input  logic [31:0]           ex_mem_addr,
  input  logic [REG_W-1:0]      ex_mem_sdata,
  output logic                  mem_we,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic [REG_W-1:0]      mem_wdata,
  output logic                  stallreq_mem,
  output logic                  mc_req,
  output logic                  mc_wr,
  output logic [ADDR_W-1:0]     mc_addr,
  output logic [BYTE_W-1:0]     mc_wdata,
  input  logic [BYTE_W-1:0]     mc_rdata,
  input  logic                  mc_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             state;
  logic [1:0]         k;
  logic [REG_W-1:0]   ld_buf;
  logic               mc_req_q;
  logic               mc_wr_q;
  logic [ADDR_W-1:0]  mc_addr_q;
  logic [BYTE_W-1:0]  mc_wdata_q;

  logic               is_ld;
  logic               is_st;
  logic [2:0]         nbytes;
  logic [1:0]         k_nxt;
  logic               last_byte;
  logic [REG_W-1:0]   ld_word;

  // ex_mem is frozen by our stall, so the ex_* inputs stay valid for the whole access.
  assign is_ld     = op_is_load(ex_mem_op);
  assign is_st     = op_is_store(ex_mem_op);
  assign nbytes    = op_nbytes(ex_mem_op);
  assign k_nxt     = k + 2'd1;
  assign last_byte = ({1'b0, k} == (nbytes - 3'd1));

  mem_load_ext u_load_ext (
    .ld_buf (ld_buf),
    .op     (ex_mem_op),
    .word   (ld_word)
  );

  // The next byte's address/data are registered on the edge that completes the
  // current one, so mc_req stays high across bytes and mc_* come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      k          <= 2'd0;
      ld_buf     <= '0;
      mc_req_q   <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_ld || is_st) begin
            state      <= S_ACCESS;
            k          <= 2'd0;
            ld_buf     <= '0;
            mc_req_q   <= 1'b1;
            mc_wr_q    <= is_st;
            mc_addr_q  <= ADDR_W'(ex_mem_addr);
            mc_wdata_q <= ex_mem_sdata[7:0];
          end
        end
        S_ACCESS: begin
          if (mc_ready) begin
            if (is_ld) ld_buf[8*k +: 8] <= mc_rdata;
            if (last_byte) begin
              state    <= S_DONE;
              mc_req_q <= 1'b0;
              mc_wr_q  <= 1'b0;
            end else begin
              k          <= k_nxt;
              // Address arithmetic wraps naturally at ADDR_W bits.
              mc_addr_q  <= ADDR_W'(ex_mem_addr) + ADDR_W'(k_nxt);
              mc_wdata_q <= ex_mem_sdata[8*k_nxt +: 8];
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    stallreq_mem = 1'b0;
    if (rst) begin
      mem_waddr = ex_waddr;
      mem_wdata = ex_wdata;
      case (state)
        S_IDLE: begin
          if (is_ld || is_st) stallreq_mem = 1'b1;
          else                mem_we       = ex_we;
        end
        S_ACCESS: stallreq_mem = 1'b1;
        S_DONE: begin
          mem_we = ex_we;
          if (is_ld) mem_wdata = ld_word;
        end
        default: ;
      endcase
    end
  end

  // Reset forces the controller port low immediately, abandoning any transfer.
  assign mc_req   = rst & mc_req_q;
  assign mc_wr    = rst & mc_wr_q;
  assign mc_addr  = {ADDR_W{rst}} & mc_addr_q;
  assign mc_wdata = {BYTE_W{rst}} & mc_wdata_q;

endmodule

// File: tb/tb_mem.sv
module tb_mem;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_sdata;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        stallreq_mem;
  logic        mc_req;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic [7:0]  mc_rdata;
  logic        mc_ready;

  mem #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stallreq_mem(stallreq_mem),
    .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_rdata(mc_rdata), .mc_ready(mc_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_img [logic [31:0]];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          waits;      // wait cycles before each byte is accepted
    logic        st;         // op is a store
    int          nbytes;
    logic        exp_we;
    logic [31:0] exp_wdata;
    int          exp_stall;  // stall cycles
    int          exp_done;   // cycle (from T) where stall drops
    logic [31:0] exp_wbytes; // bytes expected on mc_wdata, little-endian
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies one op at the current time (just after a clock edge) and acts as the
  // memory controller until stallreq_mem drops, then checks everything observed.
  task automatic run_vec(input int idx, input vec_t v);
    int          stalls = 0;
    int          dcyc = -1;
    int          waitcnt = 0;
    int          nacc = 0;
    logic        done = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] p_addr = '0;
    logic [7:0]  p_wdata = '0;
    logic        p_wr = 1'b0;
    logic        got_we = 1'b0;
    logic [31:0] got_wdata = '0;
    logic [4:0]  got_waddr = '0;
    logic [31:0] acc_a[4];
    logic [7:0]  acc_d[4];
    logic        acc_w[4];
    ex_mem_op = v.op; ex_mem_addr = v.addr; ex_mem_sdata = v.sdata;
    ex_we = v.we; ex_waddr = v.waddr; ex_wdata = v.wdata;
    mc_ready = 1'b0;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stallreq_mem) begin
        done = 1'b1; dcyc = c;
        got_we = mem_we; got_wdata = mem_wdata; got_waddr = mem_waddr;
        chk($sformatf("v%0d_done_req", idx), {31'd0, mc_req}, 32'd0);
        mc_ready = 1'b0;
      end else begin
        stalls++;
        if (mc_req) begin
          if (prev_wait) begin
            chk($sformatf("v%0d_hold_addr", idx), mc_addr, p_addr);
            chk($sformatf("v%0d_hold_data", idx), {24'd0, mc_wdata}, {24'd0, p_wdata});
            chk($sformatf("v%0d_hold_wr", idx), {31'd0, mc_wr}, {31'd0, p_wr});
          end
          if (waitcnt == v.waits) begin
            mc_ready = 1'b1;
            if (mc_wr) mem_img[mc_addr] = mc_wdata;
            else mc_rdata = mem_img.exists(mc_addr) ? mem_img[mc_addr] : 8'h00;
            if (nacc < 4) begin
              acc_a[nacc] = mc_addr; acc_d[nacc] = mc_wdata; acc_w[nacc] = mc_wr;
            end
            nacc++; waitcnt = 0; prev_wait = 1'b0;
          end else begin
            mc_ready = 1'b0; waitcnt++; prev_wait = 1'b1;
            p_addr = mc_addr; p_wdata = mc_wdata; p_wr = mc_wr;
          end
        end else begin
          mc_ready = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    mc_ready = 1'b0;
    if (!done) chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
    chk($sformatf("v%0d_we", idx), {31'd0, got_we}, {31'd0, v.exp_we});
    chk($sformatf("v%0d_waddr", idx), {27'd0, got_waddr}, {27'd0, v.waddr});
    chk($sformatf("v%0d_wdata", idx), got_wdata, v.exp_wdata);
    chk($sformatf("v%0d_stalls", idx), stalls, v.exp_stall);
    chk($sformatf("v%0d_done_cyc", idx), dcyc, v.exp_done);
    chk($sformatf("v%0d_nbytes", idx), nacc, v.nbytes);
    for (int i = 0; i < v.nbytes && i < nacc && i < 4; i++) begin
      chk($sformatf("v%0d_addr%0d", idx, i), acc_a[i], v.addr + i);
      chk($sformatf("v%0d_wr%0d", idx, i), {31'd0, acc_w[i]}, {31'd0, v.st});
      if (v.st) chk($sformatf("v%0d_byte%0d", idx, i), {24'd0, acc_d[i]},
                    {24'd0, v.exp_wbytes[8*i +: 8]});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_waddr"}, {27'd0, mem_waddr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_stall"}, {31'd0, stallreq_mem}, 32'd0);
    chk({tag, "_mc_req"}, {31'd0, mc_req}, 32'd0);
    chk({tag, "_mc_wr"}, {31'd0, mc_wr}, 32'd0);
    chk({tag, "_mc_addr"}, mc_addr, 32'd0);
    chk({tag, "_mc_wdata"}, {24'd0, mc_wdata}, 32'd0);
  endtask

  initial begin
    //           op      addr          sdata         we    wa     wdata         wt st n  ewe   ewdata        stl dn wbytes
    vecs[0]  = '{OP_NOP, 32'h0,        32'h0,        1'b1, 5'd5,  32'h00001234, 0, 0, 0, 1'b1, 32'h00001234, 0, 0, 32'h0};
    vecs[1]  = '{OP_LW,  32'h1000,     32'h0,        1'b1, 5'd3,  32'h00001000, 0, 0, 4, 1'b1, 32'h12345678, 5, 5, 32'h0};
    vecs[2]  = '{OP_LB,  32'h3000,     32'h0,        1'b1, 5'd4,  32'h00003000, 0, 0, 1, 1'b1, 32'hFFFFFF80, 2, 2, 32'h0};
    vecs[3]  = '{OP_LBU, 32'h3000,     32'h0,        1'b1, 5'd6,  32'h00003000, 0, 0, 1, 1'b1, 32'h00000080, 2, 2, 32'h0};
    vecs[4]  = '{OP_LH,  32'h3010,     32'h0,        1'b1, 5'd7,  32'h00003010, 0, 0, 2, 1'b1, 32'hFFFF8001, 3, 3, 32'h0};
    vecs[5]  = '{OP_LHU, 32'h3010,     32'h0,        1'b1, 5'd8,  32'h00003010, 0, 0, 2, 1'b1, 32'h00008001, 3, 3, 32'h0};
    vecs[6]  = '{OP_SH,  32'h2003,     32'hAABBCCDD, 1'b0, 5'd0,  32'h00002003, 2, 1, 2, 1'b0, 32'h00002003, 7, 7, 32'h0000CCDD};
    vecs[7]  = '{OP_SW,  32'hFFFFFFFE, 32'h11223344, 1'b0, 5'd0,  32'hFFFFFFFE, 0, 1, 4, 1'b0, 32'hFFFFFFFE, 5, 5, 32'h11223344};
    vecs[8]  = '{OP_LW,  32'hFFFFFFFE, 32'h0,        1'b1, 5'd10, 32'hFFFFFFFE, 0, 0, 4, 1'b1, 32'h11223344, 5, 5, 32'h0};
    vecs[9]  = '{4'hF,   32'h1000,     32'h0,        1'b1, 5'd7,  32'hCAFEF00D, 0, 0, 0, 1'b1, 32'hCAFEF00D, 0, 0, 32'h0};
    vecs[10] = '{OP_SB,  32'h1001,     32'h000000A5, 1'b0, 5'd0,  32'h00001001, 1, 1, 1, 1'b0, 32'h00001001, 3, 3, 32'h000000A5};
    vecs[11] = '{OP_LBU, 32'h1001,     32'h0,        1'b1, 5'd12, 32'h00001001, 0, 0, 1, 1'b1, 32'h000000A5, 2, 2, 32'h0};

    mem_img[32'h1000] = 8'h78; mem_img[32'h1001] = 8'h56;
    mem_img[32'h1002] = 8'h34; mem_img[32'h1003] = 8'h12;
    mem_img[32'h3000] = 8'h80;
    mem_img[32'h3010] = 8'h01; mem_img[32'h3011] = 8'h80;
    mem_img[32'h4000] = 8'hEF; mem_img[32'h4001] = 8'hBE;
    mem_img[32'h4002] = 8'hAD; mem_img[32'h4003] = 8'hDE;

    // Reset: outputs forced low even with live pass-through / memory inputs.
    rst = 1'b0; mc_ready = 1'b0; mc_rdata = 8'h00;
    ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1234;
    ex_mem_op = OP_NOP; ex_mem_addr = 32'h1000; ex_mem_sdata = 32'h0;
    @(posedge clk); #1;
    chk_all_zero("rst_nop");
    ex_mem_op = OP_LW;
    @(posedge clk); #1;
    chk_all_zero("rst_lw");
    ex_mem_op = OP_NOP;
    rst = 1'b1;
    #1;

    // Table: applied back-to-back, each op seen in IDLE the cycle after the previous DONE.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset while ACCESS is on byte 1 of an LW.
    ex_mem_op = OP_LW; ex_mem_addr = 32'h4000; ex_we = 1'b1; ex_waddr = 5'd9;
    ex_wdata = 32'h4000; mc_ready = 1'b0;
    @(posedge clk); #1;
    mc_ready = 1'b1; mc_rdata = 8'hEF;
    @(posedge clk); #1;
    chk("mid_k1_addr", mc_addr, 32'h4001);
    chk("mid_k1_stall", {31'd0, stallreq_mem}, 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    chk("mid_rst_hold_req", {31'd0, mc_req}, 32'd0);
    rst = 1'b1; mc_ready = 1'b0; ex_mem_op = OP_NOP; ex_we = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stallreq_mem}, 32'd0);
    chk("post_rst_req", {31'd0, mc_req}, 32'd0);
    chk("post_rst_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_idle_req", {31'd0, mc_req}, 32'd0);
    chk("post_rst_idle_stall", {31'd0, stallreq_mem}, 32'd0);
    run_vec(12, '{OP_LW, 32'h4000, 32'h0, 1'b1, 5'd9, 32'h4000, 0, 0, 4, 1'b1,
                  32'hDEADBEEF, 5, 5, 32'h0});

    ex_mem_op = OP_NOP;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
